imem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port instruction memory shared by the IF stage and a program loader/debug port. Issues fetches for the IF-stage PC (`i_IF_mem_ImemAddr`) and drives the IF stall so the PC holds until the instruction is delivered. Interleaves loader reads/writes with bounded starvation of fetch. Sits between IF, the loader, and the imem macro, which has fixed read latency.

---
 rtl/imem_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_imem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Arbiter and sequencer for the single-port instruction memory. The memory
// is shared by the IF stage (instruction fetch) and a program loader/debug
// port. The block issues one memory access at a time through a three-state
// sequencer (IDLE -> [WAIT] -> DONE).
//
// Loader requests win arbitration. The exception is when fetch is enabled
// and the loader has already taken MAX_LD grants in a row; one fetch is then
// forced through. This bounds how long fetch can be starved.
//
// Optional build macro:
//   IMEM_FETCH_BUF_EN - adds a one-entry fetch buffer {valid, addr, data}.
//                       A repeated fetch of the last fetched address is served
//                       from the buffer without touching memory. Any loader
//                       write invalidates the buffer.
//
// Parameters:
//   MEM_LAT  imem read latency, request to valid i_MEM_rdata (1..4)
//   MAX_LD   consecutive loader grants allowed while fetch is enabled (1..15)
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   i_IF_fetch_en        fetch requests enabled
//   i_IF_mem_ImemAddr    fetch address (PC), stable while o_IF_stall=1
//   o_IF_mem_ImemDataR   fetched instruction (held after delivery)
//   o_IF_stall           0 only in the cycle the instruction is delivered
//   i_LD_req/we/addr/wdata  loader request, held until o_LD_ack
//   o_LD_ack             single-cycle completion pulse
//   o_LD_rdata           loader read data (held after delivery)
//   o_MEM_req/we/addr/wdata  memory access strobe and command (held when idle)
//   i_MEM_rdata          memory read data, MEM_LAT cycles after a read strobe
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int MAX_LD  = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_IF_fetch_en,
    input  logic [31:0] i_IF_mem_ImemAddr,
    output logic [31:0] o_IF_mem_ImemDataR,
    output logic        o_IF_stall,
    input  logic        i_LD_req,
    input  logic        i_LD_we,
    input  logic [31:0] i_LD_addr,
    input  logic [31:0] i_LD_wdata,
    output logic        o_LD_ack,
    output logic [31:0] o_LD_rdata,
    output logic        o_MEM_req,
    output logic        o_MEM_we,
    output logic [31:0] o_MEM_addr,
    output logic [31:0] o_MEM_wdata,
    input  logic [31:0] i_MEM_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_FETCH,
        OP_LD_RD,
        OP_LD_WR
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  ld_cnt_q, ld_cnt_d;
    logic        hit_q, hit_d;

    logic [31:0] if_data_q;
    logic [31:0] ld_rdata_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        idle;
    logic        force_fetch;
    logic        grant_ld;
    logic        grant_if;
    logic        fetch_hit;
    logic        mem_issue;
    logic        deliver_if;
    logic        deliver_ld_rd;
    logic [31:0] if_rdata;
    logic [31:0] hit_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Grants are combinational so that the memory strobe goes out in the
    // same cycle as the grant. Qualifying with nrst keeps the strobe low
    // while reset is held, even though the state register already reads IDLE.
    assign idle        = (state_q == S_IDLE) && nrst;
    assign force_fetch = i_IF_fetch_en && (ld_cnt_q == 4'(MAX_LD));
    assign grant_ld    = idle && i_LD_req && !force_fetch;
    assign grant_if    = idle && !grant_ld && i_IF_fetch_en;
    assign mem_issue   = grant_ld || (grant_if && !fetch_hit);

`ifdef IMEM_FETCH_BUF_EN
    logic        buf_valid_q;
    logic [31:0] buf_addr_q;
    logic [31:0] buf_data_q;

    assign fetch_hit = grant_if && buf_valid_q && (buf_addr_q == i_IF_mem_ImemAddr);
    assign hit_data  = buf_data_q;

    // NOTE: only buf_valid_q has to be reset for correctness. The address
    // and data are cleared too, so the buffer never holds X before first use.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else if (grant_ld && i_LD_we) begin
            buf_valid_q <= 1'b0;
        end else if (state_q == S_DONE && op_q == OP_FETCH && !hit_q) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= mem_addr_q;
            buf_data_q  <= i_MEM_rdata;
        end
    end
`else
    assign fetch_hit = 1'b0;
    assign hit_data  = '0;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so that no
    // path through the case statement leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        lat_cnt_d = lat_cnt_q;
        ld_cnt_d  = ld_cnt_q;
        hit_d     = hit_q;

        case (state_q)
            S_IDLE: begin
                if (grant_ld) begin
                    op_d  = i_LD_we ? OP_LD_WR : OP_LD_RD;
                    hit_d = 1'b0;
                    // Consecutive loader grants only count while fetch is waiting.
                    if (i_IF_fetch_en)
                        ld_cnt_d = (ld_cnt_q < 4'(MAX_LD)) ? ld_cnt_q + 4'd1 : ld_cnt_q;
                    else
                        ld_cnt_d = '0;
                    // Writes have no read data to wait for.
                    if (i_LD_we || MEM_LAT == 1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_WAIT;
                        lat_cnt_d = 3'(MEM_LAT - 1);
                    end
                end else if (grant_if) begin
                    op_d     = OP_FETCH;
                    hit_d    = fetch_hit;
                    ld_cnt_d = '0;
                    if (fetch_hit || MEM_LAT == 1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_WAIT;
                        lat_cnt_d = 3'(MEM_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    state_d   = S_DONE;
                    lat_cnt_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_FETCH;
            lat_cnt_q <= '0;
            ld_cnt_q  <= '0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            lat_cnt_q <= lat_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
            hit_q     <= hit_d;
        end
    end

    // ------------------------------------------------------------------
    // Result delivery: bypass in DONE, registered copy held afterwards
    // ------------------------------------------------------------------
    assign deliver_if    = (state_q == S_DONE) && (op_q == OP_FETCH);
    assign deliver_ld_rd = (state_q == S_DONE) && (op_q == OP_LD_RD);
    assign if_rdata      = hit_q ? hit_data : i_MEM_rdata;

    assign o_IF_stall         = !deliver_if;
    assign o_IF_mem_ImemDataR = deliver_if ? if_rdata : if_data_q;
    assign o_LD_ack           = (state_q == S_DONE) && (op_q != OP_FETCH);
    assign o_LD_rdata         = deliver_ld_rd ? i_MEM_rdata : ld_rdata_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            if_data_q  <= '0;
            ld_rdata_q <= '0;
        end else begin
            if (deliver_if)
                if_data_q <= if_rdata;
            if (deliver_ld_rd)
                ld_rdata_q <= i_MEM_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Memory command: driven live on issue, last value held otherwise
    // ------------------------------------------------------------------
    assign o_MEM_req   = mem_issue;
    assign o_MEM_we    = mem_issue ? (grant_ld && i_LD_we) : mem_we_q;
    assign o_MEM_addr  = mem_issue ? (grant_ld ? i_LD_addr : i_IF_mem_ImemAddr) : mem_addr_q;
    assign o_MEM_wdata = (mem_issue && grant_ld) ? i_LD_wdata : mem_wdata_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (mem_issue) begin
            mem_we_q    <= o_MEM_we;
            mem_addr_q  <= o_MEM_addr;
            mem_wdata_q <= o_MEM_wdata;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed and randomized bench for imem_arbiter (MEM_LAT=2, MAX_LD=4).
// A small behavioural memory with fixed read latency stands in for the imem
// macro. Expected results come from a transaction-level reference: an array
// holding the expected memory contents, the last delivered fetch and loader
// data, and a view of the fetch buffer when IMEM_FETCH_BUF_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_arbiter;

    localparam int MEM_LAT = 2;
    localparam int MAX_LD  = 4;
`ifdef IMEM_FETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk;
    logic        nrst;
    logic        i_IF_fetch_en;
    logic [31:0] i_IF_mem_ImemAddr;
    logic [31:0] o_IF_mem_ImemDataR;
    logic        o_IF_stall;
    logic        i_LD_req;
    logic        i_LD_we;
    logic [31:0] i_LD_addr;
    logic [31:0] i_LD_wdata;
    logic        o_LD_ack;
    logic [31:0] o_LD_rdata;
    logic        o_MEM_req;
    logic        o_MEM_we;
    logic [31:0] o_MEM_addr;
    logic [31:0] o_MEM_wdata;
    logic [31:0] i_MEM_rdata;

    imem_arbiter #(
        .MEM_LAT (MEM_LAT),
        .MAX_LD  (MAX_LD)
    ) dut (
        .clk                (clk),
        .nrst               (nrst),
        .i_IF_fetch_en      (i_IF_fetch_en),
        .i_IF_mem_ImemAddr  (i_IF_mem_ImemAddr),
        .o_IF_mem_ImemDataR (o_IF_mem_ImemDataR),
        .o_IF_stall         (o_IF_stall),
        .i_LD_req           (i_LD_req),
        .i_LD_we            (i_LD_we),
        .i_LD_addr          (i_LD_addr),
        .i_LD_wdata         (i_LD_wdata),
        .o_LD_ack           (o_LD_ack),
        .o_LD_rdata         (o_LD_rdata),
        .o_MEM_req          (o_MEM_req),
        .o_MEM_we           (o_MEM_we),
        .o_MEM_addr         (o_MEM_addr),
        .o_MEM_wdata        (o_MEM_wdata),
        .i_MEM_rdata        (i_MEM_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory macro model (64 words, fixed read latency, backdoor preload)
    // ------------------------------------------------------------------
    logic [31:0] mem     [0:63];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (o_MEM_req && o_MEM_we)
            mem[o_MEM_addr[7:2]] <= o_MEM_wdata;
        if (o_MEM_req && !o_MEM_we)
            rd_pipe[0] <= mem[o_MEM_addr[7:2]];
        for (int i = 1; i < MEM_LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_MEM_rdata = rd_pipe[MEM_LAT-1];

    // ------------------------------------------------------------------
    // Reference state and bookkeeping
    // ------------------------------------------------------------------
    logic [31:0] exp_mem [0:63];
    bit          buf_v;
    logic [31:0] buf_a;
    logic [31:0] last_if;
    logic [31:0] last_ld;
    int          n_cmp;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle; inputs set afterwards apply to that cycle.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // One fetch starting in IDLE. Optionally drops fetch_en after the issue.
    task automatic run_fetch(input logic [31:0] pc, input bit drop_en);
        bit          hit;
        bit          done;
        int          k;
        logic [31:0] exp_d;
        hit   = BUF_EN && buf_v && (buf_a == pc);
        exp_d = exp_mem[pc[7:2]];
        i_IF_fetch_en     = 1'b1;
        i_IF_mem_ImemAddr = pc;
        i_LD_req          = 1'b0;
        #1;
        check("if_issue_req", 32'(o_MEM_req), 32'(!hit));
        check("if_issue_stall", 32'(o_IF_stall), 32'd1);
        check("if_held_data", o_IF_mem_ImemDataR, last_if);
        if (!hit) begin
            check("if_issue_addr", o_MEM_addr, pc);
            check("if_issue_we", 32'(o_MEM_we), 32'd0);
        end
        k    = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            next_cycle();
            k++;
            if (drop_en) i_IF_fetch_en = 1'b0;
            #1;
            if (o_IF_stall === 1'b0) done = 1'b1;
        end
        check("if_latency", 32'(k), hit ? 32'd1 : 32'(MEM_LAT));
        check("if_data", o_IF_mem_ImemDataR, exp_d);
        last_if = exp_d;
        buf_v   = 1'b1;
        buf_a   = pc;
        next_cycle();
        i_IF_fetch_en = 1'b0;
        #1;
        check("if_stall_after", 32'(o_IF_stall), 32'd1);
    endtask

    // One loader access starting in IDLE with fetch parked.
    task automatic run_ld(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit          done;
        bit          stall_bad;
        int          k;
        logic [31:0] exp_r;
        exp_r = we ? last_ld : exp_mem[addr[7:2]];
        i_IF_fetch_en = 1'b0;
        i_LD_req      = 1'b1;
        i_LD_we       = we;
        i_LD_addr     = addr;
        i_LD_wdata    = wdata;
        #1;
        check("ld_issue_req", 32'(o_MEM_req), 32'd1);
        check("ld_issue_we", 32'(o_MEM_we), 32'(we));
        check("ld_issue_addr", o_MEM_addr, addr);
        if (we) check("ld_issue_wdata", o_MEM_wdata, wdata);
        check("ld_held_rdata", o_LD_rdata, last_ld);
        stall_bad = (o_IF_stall !== 1'b1);
        k    = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            next_cycle();
            k++;
            #1;
            if (o_IF_stall !== 1'b1) stall_bad = 1'b1;
            if (o_LD_ack === 1'b1) done = 1'b1;
        end
        check("ld_latency", 32'(k), we ? 32'd1 : 32'(MEM_LAT));
        check("ld_rdata", o_LD_rdata, exp_r);
        check("ld_stall_held", 32'(stall_bad), 32'd0);
        if (we) begin
            exp_mem[addr[7:2]] = wdata;
            buf_v = 1'b0;
        end else begin
            last_ld = exp_r;
        end
        next_cycle();
        i_LD_req = 1'b0;
        #1;
        check("ld_ack_pulse", 32'(o_LD_ack), 32'd0);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_stall"}, 32'(o_IF_stall), 32'd1);
        check({phase, "_if_data"}, o_IF_mem_ImemDataR, 32'd0);
        check({phase, "_ack"}, 32'(o_LD_ack), 32'd0);
        check({phase, "_ld_rdata"}, o_LD_rdata, 32'd0);
        check({phase, "_mem_req"}, 32'(o_MEM_req), 32'd0);
        check({phase, "_mem_we"}, 32'(o_MEM_we), 32'd0);
        check({phase, "_mem_addr"}, o_MEM_addr, 32'd0);
        check({phase, "_mem_wdata"}, o_MEM_wdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] got_mask;
        logic [31:0] exp_mask;
        logic [31:0] pc_s;
        logic [31:0] la_s;
        logic [31:0] wd;
        logic [31:0] a;
        int          mc;
        int          n_done;
        int          k;

        n_cmp   = 0;
        n_fail  = 0;
        buf_v   = 1'b0;
        buf_a   = '0;
        last_if = '0;
        last_ld = '0;

        nrst              = 1'b0;
        i_IF_fetch_en     = 1'b1;
        i_IF_mem_ImemAddr = 32'h0;
        i_LD_req          = 1'b1;
        i_LD_we           = 1'b0;
        i_LD_addr         = 32'h0;
        i_LD_wdata        = 32'h0;
        bd_we             = 1'b0;
        bd_addr           = '0;
        bd_data           = '0;

        // Preload memory while reset is held.
        for (int i = 0; i < 64; i++) begin
            wd = (i == 0) ? 32'h2008_0005 : $urandom;
            exp_mem[i] = wd;
            bd_we   = 1'b1;
            bd_addr = 6'(i);
            bd_data = wd;
            next_cycle();
        end
        bd_we = 1'b0;
        #1;
        // Requests pending during reset must not reach memory.
        check_reset_outputs("rst");

        next_cycle();
        nrst     = 1'b1;
        i_LD_req = 1'b0;

        // First fetch from PC 0, then back-to-back fetches of PC 8.
        run_fetch(32'h0, 1'b0);
        run_fetch(32'h8, 1'b0);
        run_fetch(32'h8, 1'b0);
        run_ld(1'b1, 32'h8, 32'h1357_9bdf);
        run_fetch(32'h8, 1'b0);

        // Loader write then read with fetch parked.
        run_ld(1'b1, 32'h40, 32'hDEAD_BEEF);
        run_ld(1'b0, 32'h40, 32'h0);

        // Fairness: loader held high with fetch enabled.
        run_fetch(32'h10, 1'b0);
        pc_s = 32'h14;
        la_s = 32'h20;
        exp_mask = '0;
        mc = 0;
        for (int i = 0; i < 10; i++) begin
            if (mc == MAX_LD) begin
                exp_mask[i] = 1'b1;
                mc = 0;
            end else begin
                mc++;
            end
        end
        got_mask = '0;
        n_done   = 0;
        k        = 0;
        i_IF_fetch_en     = 1'b1;
        i_IF_mem_ImemAddr = pc_s;
        i_LD_req          = 1'b1;
        i_LD_we           = 1'b0;
        i_LD_addr         = la_s;
        while (n_done < 10 && k < 200) begin
            #1;
            if (o_IF_stall === 1'b0) begin
                got_mask[n_done] = 1'b1;
                check("seq_if_data", o_IF_mem_ImemDataR, exp_mem[pc_s[7:2]]);
                n_done++;
            end else if (o_LD_ack === 1'b1) begin
                check("seq_ld_rdata", o_LD_rdata, exp_mem[la_s[7:2]]);
                n_done++;
            end
            next_cycle();
            k++;
        end
        i_IF_fetch_en = 1'b0;
        i_LD_req      = 1'b0;
        check("seq_count", 32'(n_done), 32'd10);
        check("seq_grants", got_mask, exp_mask);
        last_if = exp_mem[pc_s[7:2]];
        last_ld = exp_mem[la_s[7:2]];
        buf_v   = 1'b1;
        buf_a   = pc_s;

        // Loader request arriving during a fetch WAIT cycle.
        i_IF_fetch_en     = 1'b1;
        i_IF_mem_ImemAddr = 32'h30;
        #1;
        check("wait_if_issue", 32'(o_MEM_req), 32'd1);
        next_cycle();
        i_LD_req   = 1'b1;
        i_LD_we    = 1'b1;
        i_LD_addr  = 32'h34;
        i_LD_wdata = 32'hA5A5_0F0F;
        #1;
        check("wait_no_issue", 32'(o_MEM_req), 32'd0);
        check("wait_no_ack", 32'(o_LD_ack), 32'd0);
        next_cycle();
        #1;
        check("wait_if_stall", 32'(o_IF_stall), 32'd0);
        check("wait_if_data", o_IF_mem_ImemDataR, exp_mem[12]);
        last_if = exp_mem[12];
        next_cycle();
        #1;
        check("wait_ld_issue", 32'(o_MEM_req), 32'd1);
        check("wait_ld_we", 32'(o_MEM_we), 32'd1);
        check("wait_ld_addr", o_MEM_addr, 32'h34);
        next_cycle();
        #1;
        check("wait_ld_ack", 32'(o_LD_ack), 32'd1);
        exp_mem[13] = 32'hA5A5_0F0F;
        buf_v = 1'b0;
        next_cycle();
        i_LD_req      = 1'b0;
        i_IF_fetch_en = 1'b0;
        run_ld(1'b0, 32'h34, 32'h0);

        // Reset pulse during the WAIT of a loader read.
        i_LD_req  = 1'b1;
        i_LD_we   = 1'b0;
        i_LD_addr = 32'h44;
        #1;
        check("rw_issue", 32'(o_MEM_req), 32'd1);
        next_cycle();
        #1;
        nrst = 1'b0;
        #1;
        check_reset_outputs("rw");
        next_cycle();
        #1;
        check("rw_no_ack", 32'(o_LD_ack), 32'd0);
        next_cycle();
        nrst     = 1'b1;
        i_LD_req = 1'b0;
        last_if  = '0;
        last_ld  = '0;
        buf_v    = 1'b0;
        next_cycle();
        run_ld(1'b0, 32'h44, 32'h0);

        // Randomized mix over a small address window.
        for (int n = 0; n < 40; n++) begin
            a = 32'($urandom_range(0, 7)) << 2;
            case ($urandom_range(0, 3))
                0, 1:    run_fetch(a, 1'($urandom_range(0, 1)));
                2:       run_ld(1'b0, a, 32'h0);
                default: run_ld(1'b1, a, $urandom);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
